// File: rtl/seg7_scan_driver_if.sv
// Valid/ready word bus between the stopwatch (master) and the display scanner (slave).
// Carries one 4-digit BCD word per accepted transfer.
interface seg7_scan_driver_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver with frame-aligned word updates.
// Optional PWM dimming is enabled by defining SEG7_DIM_EN (adds the brightness input).
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus,
  input  logic                blank_lz,
  input  logic [3:0]          dp_mask,
`ifdef SEG7_DIM_EN
  input  logic [3:0]          brightness,
`endif
  output logic [6:0]          seg,
  output logic                dp,
  output logic [3:0]          an,
  output logic                frame_tick
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pend_q, pend_d;
  logic          pendFull_q, pendFull_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;
`ifdef SEG7_DIM_EN
  logic [3:0]    pwm_q;
`endif

  logic          boundary;
  logic          inGuard;
  logic          digitOn;
  logic [3:0]    nibble;
  logic [3:0]    nibZero;
  logic [3:0]    blanked;

  function automatic logic [6:0] decodeBcd(input logic [3:0] n);
    case (n)
      4'd0:    decodeBcd = 7'b1000000;
      4'd1:    decodeBcd = 7'b1111001;
      4'd2:    decodeBcd = 7'b0100100;
      4'd3:    decodeBcd = 7'b0110000;
      4'd4:    decodeBcd = 7'b0011001;
      4'd5:    decodeBcd = 7'b0010010;
      4'd6:    decodeBcd = 7'b0000010;
      4'd7:    decodeBcd = 7'b1111000;
      4'd8:    decodeBcd = 7'b0000000;
      4'd9:    decodeBcd = 7'b0010000;
      default: decodeBcd = 7'b0111111;
    endcase
  endfunction

  assign bus.data_ready = ~pendFull_q;
  assign seg            = seg_q;
  assign dp             = dp_q;
  assign an             = an_q;
  assign frame_tick     = tick_q;

  // Output decode for the slot the counter is in now; registered, so pins lag by one clock.
  always_comb begin
    nibble = 4'd0;
    case (idx_q)
      2'd0: nibble = active_q[3:0];
      2'd1: nibble = active_q[7:4];
      2'd2: nibble = active_q[11:8];
      2'd3: nibble = active_q[15:12];
      default: nibble = 4'd0;
    endcase

    nibZero[0] = (active_q[3:0]   == 4'd0);
    nibZero[1] = (active_q[7:4]   == 4'd0);
    nibZero[2] = (active_q[11:8]  == 4'd0);
    nibZero[3] = (active_q[15:12] == 4'd0);

    blanked[3] = blank_lz & nibZero[3];
    blanked[2] = blanked[3] & nibZero[2];
    blanked[1] = blanked[2] & nibZero[1];
    blanked[0] = 1'b0;

    inGuard  = (cnt_q < GUARD_END);
    boundary = (idx_q == 2'd3) && (cnt_q == CNT_LAST);

`ifdef SEG7_DIM_EN
    digitOn = ~blanked[idx_q] & (pwm_q <= brightness);
`else
    digitOn = ~blanked[idx_q];
`endif

    seg_d  = (inGuard || blanked[idx_q]) ? 7'h7F : decodeBcd(nibble);
    an_d   = (inGuard || !digitOn) ? 4'hF : ~(4'b0001 << idx_q);
    dp_d   = inGuard ? 1'b1 : ~dp_mask[idx_q];
    tick_d = boundary;
  end

  // Scan position and word buffering; a pending word only moves to active at a frame boundary.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pendFull_d = pendFull_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (boundary && pendFull_q) begin
      active_d   = pend_q;
      pendFull_d = 1'b0;
    end else if (bus.data_valid && !pendFull_q) begin
      pend_d     = bus.data_in;
      pendFull_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      active_q   <= 16'h0000;
      pend_q     <= 16'h0000;
      pendFull_q <= 1'b0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= 4'hF;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pendFull_q <= pendFull_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
    end
  end

`ifdef SEG7_DIM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGIT_CYCLES=8, GUARD_CYCLES=1.
// Each frame is checked sample by sample against hand-derived segment codes.
module tb_seg7_scan_driver;
  localparam int DC = 8;
  localparam int GC = 1;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic       blankLz;
  logic [3:0] dpMask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frameTick;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .DIGIT_CYCLES(DC),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .blank_lz   (blankLz),
    .dp_mask    (dpMask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frameTick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a word and holds it until the scanner takes it.
  task automatic applyStimulus(input logic [15:0] word);
    int waited = 0;
    bus.data_in    = word;
    bus.data_valid = 1'b1;
    while (!bus.data_ready && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("send_ready", {15'd0, bus.data_ready}, 16'd1);
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic waitFrameTick();
    int waited = 0;
    do begin
      tick();
      waited++;
    end while (!frameTick && waited < 100);
    checkOutput("frame_tick_wait", {15'd0, frameTick}, 16'd1);
  endtask

  // Called on the sample where frame_tick is high; walks the next 32 samples.
  task automatic checkFrame(input string name,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input logic [3:0] onMask, input logic [3:0] dpm);
    logic [6:0] expSeg;
    logic [3:0] expAn;
    logic       expDp;
    logic [6:0] digitSeg;
    for (int k = 1; k <= 4 * DC; k++) begin
      int d;
      int c;
      tick();
      if (k == 1) bus.data_valid = 1'b0;
      d = (k - 1) / DC;
      c = (k - 1) % DC;
      case (d)
        0: digitSeg = s0;
        1: digitSeg = s1;
        2: digitSeg = s2;
        default: digitSeg = s3;
      endcase
      if (c < GC) begin
        expSeg = SEG_OFF;
        expAn  = 4'hF;
        expDp  = 1'b1;
      end else if (onMask[d]) begin
        expSeg = digitSeg;
        expAn  = ~(4'b0001 << d);
        expDp  = ~dpm[d];
      end else begin
        expSeg = SEG_OFF;
        expAn  = 4'hF;
        expDp  = ~dpm[d];
      end
      checkOutput($sformatf("%s seg k%0d", name, k), {9'd0, seg}, {9'd0, expSeg});
      checkOutput($sformatf("%s an k%0d", name, k), {12'd0, an}, {12'd0, expAn});
      checkOutput($sformatf("%s dp k%0d", name, k), {15'd0, dp}, {15'd0, expDp});
      checkOutput($sformatf("%s tick k%0d", name, k), {15'd0, frameTick},
                  (k == 4 * DC) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_in    = 16'h0000;
    bus.data_valid = 1'b0;
    blankLz        = 1'b0;
    dpMask         = 4'b0000;

    #22;
    checkOutput("reset seg", {9'd0, seg}, 16'h007F);
    checkOutput("reset an", {12'd0, an}, 16'h000F);
    checkOutput("reset dp", {15'd0, dp}, 16'd1);
    checkOutput("reset tick", {15'd0, frameTick}, 16'd0);
    checkOutput("reset ready", {15'd0, bus.data_ready}, 16'd1);
    rst = 1'b0;

    // Basic word, shown one frame after capture.
    applyStimulus(16'h1234);
    waitFrameTick();
    checkFrame("w1234", SEG_1, SEG_2, SEG_3, SEG_4, 4'hF, 4'h0);

    // Leading-zero blanking, then the same word unblanked.
    blankLz = 1'b1;
    applyStimulus(16'h0050);
    waitFrameTick();
    checkFrame("w0050lz", SEG_OFF, SEG_OFF, SEG_5, SEG_0, 4'b0011, 4'h0);
    blankLz = 1'b0;
    checkFrame("w0050", SEG_0, SEG_0, SEG_5, SEG_0, 4'hF, 4'h0);

    // Back-to-back words: second one is held until the first goes active.
    applyStimulus(16'h1111);
    checkOutput("held ready low", {15'd0, bus.data_ready}, 16'd0);
    bus.data_in    = 16'h2222;
    bus.data_valid = 1'b1;
    waitFrameTick();
    checkOutput("ready after boundary", {15'd0, bus.data_ready}, 16'd1);
    checkFrame("w1111", SEG_1, SEG_1, SEG_1, SEG_1, 4'hF, 4'h0);
    checkFrame("w2222", SEG_2, SEG_2, SEG_2, SEG_2, 4'hF, 4'h0);

    // Word captured on the boundary edge itself waits a full frame.
    for (int i = 0; i < 4 * DC - 1; i++) tick();
    bus.data_in    = 16'h5678;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    checkOutput("boundary tick", {15'd0, frameTick}, 16'd1);
    checkOutput("boundary captured", {15'd0, bus.data_ready}, 16'd0);
    checkFrame("w2222b", SEG_2, SEG_2, SEG_2, SEG_2, 4'hF, 4'h0);
    checkFrame("w5678", SEG_5, SEG_6, SEG_7, SEG_8, 4'hF, 4'h0);

    // Non-BCD dashes and decimal point on digit 2.
    dpMask = 4'b0100;
    applyStimulus(16'h00AF);
    waitFrameTick();
    checkFrame("w00AF", SEG_0, SEG_0, SEG_DASH, SEG_DASH, 4'hF, 4'b0100);

    // A non-BCD nibble stops leading-zero blanking.
    dpMask  = 4'b0000;
    blankLz = 1'b1;
    applyStimulus(16'h0A05);
    waitFrameTick();
    checkFrame("w0A05lz", SEG_OFF, SEG_DASH, SEG_0, SEG_5, 4'b0111, 4'h0);

    // Asynchronous reset mid-slot with a word still pending.
    applyStimulus(16'h9999);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("pre-reset an", {12'd0, an}, 16'h000D);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async seg", {9'd0, seg}, 16'h007F);
    checkOutput("async an", {12'd0, an}, 16'h000F);
    checkOutput("async dp", {15'd0, dp}, 16'd1);
    checkOutput("async ready", {15'd0, bus.data_ready}, 16'd1);
    checkOutput("async tick", {15'd0, frameTick}, 16'd0);
    #2;
    rst     = 1'b0;
    blankLz = 1'b0;
    checkFrame("post-reset", SEG_0, SEG_0, SEG_0, SEG_0, 4'hF, 4'h0);
    checkFrame("pending lost", SEG_0, SEG_0, SEG_0, SEG_0, 4'hF, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumer end of the stopwatch's 4-digit BCD output bus: accepts BCD words over a valid/ready handshake and drives the Basys 3 four-digit common-anode 7-segment display.
- Time-multiplexes the digits, with a per-slot ghosting guard, optional leading-zero blanking and decimal-point control.
- New words are applied only at frame boundaries, so a frame never shows digits from two different words.
- Sits between the stopwatch and the board pins seg/an/dp.

Parameters:
- DIGIT_CYCLES, 100000, clocks per digit slot (1 kHz slot rate, 250 Hz frame at 100 MHz); legal range 4..2^20.
- GUARD_CYCLES, 2, clocks at the start of each slot with all anodes off; must be < DIGIT_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  16  BCD word; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- data_valid  in  1  producer offers data_in.
- data_ready  out  1  pending buffer empty; a word is accepted when data_valid and data_ready are both high.
- blank_lz  in  1  enable leading-zero blanking.
- dp_mask  in  4  bit i lights the decimal point on digit i.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- an  out  4  anodes, active-low; an[i] selects digit i.
- frame_tick  out  1  one-cycle pulse after digit 3's slot completes.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: seg=7'h7F, dp=1, an=4'hF, frame_tick=0, data_ready=1, active word=16'h0000, pending buffer empty, digit index=0, slot counter=0.
- Slot counter cnt runs 0..DIGIT_CYCLES-1. When cnt=DIGIT_CYCLES-1, cnt returns to 0 and the digit index advances 0→1→2→3→0.
- All outputs are registered and lag the cnt/index state by exactly 1 clock.
- After reset is released, the digit-0 slot starts on the first clock edge.
- Guard: while cnt < GUARD_CYCLES, an=4'hF, seg=7'h7F, dp=1.
- Outside the guard, an is one-hot low on the current index, unless that digit is blanked.
- seg decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Non-BCD nibbles A–F show a dash, 0111111.
- Leading-zero blanking (blank_lz=1), evaluated on the active word:
  - digit 3 is blanked if its nibble is 0;
  - digit 2 is blanked if digits 3 and 2 are both 0;
  - digit 1 is blanked if digits 3, 2 and 1 are all 0;
  - digit 0 is never blanked.
  - A non-BCD nibble counts as non-zero.
- Blanked digit: its anode stays high and seg=7'h7F for the whole slot. dp is also invisible because the anode is off.
- dp = ~dp_mask[index] outside the guard. dp_mask and blank_lz are sampled live every cycle, not frame-latched.
- Handshake:
  - On valid&&ready, data_in is captured into the pending buffer and data_ready drops on the next edge.
  - data_valid while data_ready=0: the word is not captured; the producer must hold it.
  - data_in is don't-care while data_valid=0.
- Frame boundary (index=3 and cnt=DIGIT_CYCLES-1):
  - If the pending buffer was full before this edge, pending→active and data_ready rises on the same edge.
  - frame_tick is high for the following cycle.
- Boundary acceptance: a word accepted on the boundary edge itself goes into the pending buffer and reaches the display one frame later. It never bypasses the buffer.
- Latency: an accepted word is visible at the first digit-0 slot after the next frame boundary. Worst case is 4*DIGIT_CYCLES+2 clocks.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously), and any pending word is discarded.

Optional Feature:
- Macro: SEG7_DIM_EN.
- When defined:
  - adds input brightness[3:0];
  - a free-running 4-bit PWM counter advances every clock;
  - an active anode is driven low only while pwm_cnt <= brightness, otherwise an=4'hF;
  - brightness=15 gives full on; brightness=0 gives a 1/16 duty cycle.
- When undefined: the port is absent and anodes are fully on outside the guard and blanking.

Test Plan:
- DIGIT_CYCLES=8, GUARD=1. Reset, then send 16'h1234 → after the next frame boundary the digit-0 slot shows an=1110, seg=0011001 ("4"). Digits 1, 2 and 3 show "3", "2" and "1" in order, each asserted for 7 clocks.
- Send 16'h0050 with blank_lz=1 → an[3] and an[2] stay high for the whole frame; digit 1 shows "5", digit 0 shows "0". With blank_lz=0, digits 3 and 2 show 1000000.
- Send 16'h1111, then immediately send 16'h2222 → data_ready=0 after the first word, the second word is held, and the display never mixes 1s and 2s within a frame. 2222 appears exactly one frame after 1111.
- Word accepted on the exact frame-boundary edge → the display changes one frame later, not at that boundary; frame_tick pulses once per 32 clocks.
- Send 16'h00AF with dp_mask=4'b0100 → digits 1 and 0 show a dash (0111111), dp is low only in the digit-2 slot, and the guard cycles show an=1111.
- Assert rst mid-slot → seg, an, dp and data_ready reach their reset values without a clock edge; the pending word is lost.
